serial_adder: RTL and testbench
===============================

Name: serial_adder

Overview:
Bit-serial N-bit adder. It is the sequential stage that consumes half-adder sum/carry outputs.
- Operands are captured on a start handshake.
- Bits are processed LSB-first, one per clock, through a single full-adder cell (two half-adders plus an OR).
- The carry is held in a flip-flop between bits.
- The N-bit sum and carry-out are presented with a one-cycle done pulse.
- Serves as the area-minimal adder option in the gate-level library.

Parameters:
- WIDTH, 8, operand/sum width in bits; legal range WIDTH >= 2.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start_i  input  1  request to begin an addition; sampled only when busy_o = 0.
- a_i  input  WIDTH  operand A; captured on an accepted start.
- b_i  input  WIDTH  operand B; captured on an accepted start.
- busy_o  output  1  high while bits are being processed.
- done_o  output  1  one-cycle pulse: result valid.
- sum_o  output  WIDTH  sum; held stable from done_o until the next accepted start.
- cout_o  output  1  final carry-out; same validity as sum_o.

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values: state = IDLE; busy_o = 0, done_o = 0, sum_o = 0, cout_o = 0; operand shift registers = 0; carry FF = 0; bit counter = 0.
- Reset asserted mid-operation aborts immediately to the reset values. No done_o pulse is generated for the aborted operation.
- States: IDLE, RUN, DONE.
- IDLE:
  - start_i = 1 at a rising edge: load a_sr <= a_i, b_sr <= b_i, carry <= 0, cnt <= 0, go to RUN.
  - Otherwise stay in IDLE.
- RUN (busy_o = 1), at each edge:
  - s = a_sr[0] ^ b_sr[0] ^ carry; carry <= majority(a_sr[0], b_sr[0], carry).
  - a_sr and b_sr shift right by one, filling 0.
  - Result register shifts right with s entering at bit WIDTH-1.
  - cnt <= cnt + 1.
  - On the edge where cnt = WIDTH-1: go to DONE, transfer the result register to sum_o, and transfer the new carry to cout_o.
- DONE (busy_o = 0, done_o = 1 for exactly this cycle):
  - start_i = 1: accept new operands exactly as in IDLE and go to RUN (back-to-back operation).
  - Otherwise go to IDLE.
- Latency:
  - Start accepted at edge k.
  - busy_o is high for cycles k+1 .. k+WIDTH.
  - done_o is high in the cycle following edge k+WIDTH.
  - Throughput is one result per WIDTH+1 cycles.
- start_i while busy_o = 1 is ignored: no effect on operands, carry, counter or outputs.
- sum_o/cout_o update only at the RUN->DONE transition and hold between transitions. a_i/b_i may change freely after capture.
- Arithmetic: {cout_o, sum_o} = a + b modulo 2^(WIDTH+1), unsigned. No overflow flag; cout_o is the carry.
- Counter width: $clog2(WIDTH). It wraps only through reload; it never counts past WIDTH-1.

Decomposition:
- Shared package serial_adder_pkg:
  - state_t enum {IDLE, RUN, DONE}, 2-bit encoding.
  - Localparam CNT_W = $clog2(WIDTH), supplied as a function of WIDTH.
- One sub-module: full_adder_cell (inputs a, b, cin; outputs s, cout).
  - Built from two half-adder instances plus an OR gate.
  - Purely combinational, instantiated once.
- All state lives in serial_adder.

Test Plan:
1. Reset, then start with a_i = 0x00, b_i = 0x00 (WIDTH = 8) -> busy_o high for 8 cycles, done_o one pulse, sum_o = 0x00, cout_o = 0.
2. a_i = 0xFF, b_i = 0x01 -> done_o after 8 busy cycles, sum_o = 0x00, cout_o = 1 (full carry ripple).
3. a_i = 0xA5, b_i = 0x5A; at the 3rd busy cycle pulse start_i with a_i = 0x11, b_i = 0x22 -> second start ignored, sum_o = 0xFF, cout_o = 0.
4. Hold start_i high continuously with 0x0F + 0x01, then 0x80 + 0x80 presented in the DONE cycle:
   - first result sum_o = 0x10, cout_o = 0.
   - second operation starts immediately; result sum_o = 0x00, cout_o = 1.
   - done_o pulses exactly every 9 cycles.
5. Start 0x7F + 0x7F, drop rst_n for 1 cycle at the 4th busy cycle -> all outputs return to 0 asynchronously and no done_o pulse. A subsequent start with 0x03 + 0x04 gives sum_o = 0x07.
6. Random regression: 1000 random a/b pairs, WIDTH = 8 and WIDTH = 5 -> {cout_o, sum_o} equals a + b on every done_o pulse; busy_o never overlaps done_o.

Source files
------------

// File: rtl/serial_adder_pkg.sv
// Shared types and sizing helpers for the bit-serial adder.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEFAULT_WIDTH = 8;

  // Bit counter width; the counter only ever holds 0 .. width-1.
  function automatic int cnt_width(input int width);
    return $clog2(width);
  endfunction

  localparam int CNT_W = cnt_width(DEFAULT_WIDTH);

endpackage

// File: rtl/serial_adder_full_adder_cell.sv
// One-bit full adder assembled from two half-adders and an OR gate.
module half_adder (
  input  logic a_i,
  input  logic b_i,
  output logic s_o,
  output logic c_o
);
  assign s_o = a_i ^ b_i;
  assign c_o = a_i & b_i;
endmodule

module full_adder_cell (
  input  logic a_i,
  input  logic b_i,
  input  logic cin_i,
  output logic s_o,
  output logic cout_o
);
  logic s0;
  logic c0;
  logic c1;

  half_adder u_ha0 (.a_i(a_i), .b_i(b_i),   .s_o(s0),  .c_o(c0));
  half_adder u_ha1 (.a_i(s0),  .b_i(cin_i), .s_o(s_o), .c_o(c1));

  // The two half-adder carries can never both be set, so OR gives the majority.
  assign cout_o = c0 | c1;
endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one full-adder cell, LSB first, carry held in a flop.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] sum_o,
  output logic             cout_o
);

  localparam int                 CW       = cnt_width(WIDTH);
  localparam logic [CW-1:0]      LAST_CNT = CW'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sr_q, a_sr_d;
  logic [WIDTH-1:0] b_sr_q, b_sr_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic             fa_s;
  logic             fa_cout;
  logic             accept;
  logic             running;
  logic             last_bit;

  full_adder_cell u_fa (
    .a_i    (a_sr_q[0]),
    .b_i    (b_sr_q[0]),
    .cin_i  (carry_q),
    .s_o    (fa_s),
    .cout_o (fa_cout)
  );

  // A start is honoured in IDLE and in DONE, never while bits are in flight.
  assign running  = (state_q == RUN);
  assign accept   = start_i && !running;
  assign last_bit = running && (cnt_q == LAST_CNT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start_i) state_d = RUN;
      RUN:     if (last_bit) state_d = DONE;
      DONE:    state_d = start_i ? RUN : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy_o = (state_q == RUN);
    done_o = (state_q == DONE);
    sum_o  = sum_q;
    cout_o = cout_q;
  end

  always_comb begin
    a_sr_d  = a_sr_q;
    b_sr_d  = b_sr_q;
    res_d   = res_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    cnt_d   = cnt_q;
    if (accept) begin
      a_sr_d  = a_i;
      b_sr_d  = b_i;
      carry_d = 1'b0;
      cnt_d   = '0;
    end else if (running) begin
      a_sr_d  = {1'b0, a_sr_q[WIDTH-1:1]};
      b_sr_d  = {1'b0, b_sr_q[WIDTH-1:1]};
      res_d   = {fa_s, res_q[WIDTH-1:1]};
      carry_d = fa_cout;
      // Hold the counter on the final bit so it never leaves 0 .. WIDTH-1.
      cnt_d   = last_bit ? cnt_q : cnt_q + 1'b1;
      if (last_bit) begin
        sum_d  = res_d;
        cout_d = fa_cout;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sr_q  <= '0;
      b_sr_q  <= '0;
      res_q   <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      a_sr_q  <= a_sr_d;
      b_sr_q  <= b_sr_d;
      res_q   <= res_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// Directed and random checks of serial_adder at WIDTH = 8 and WIDTH = 5.
module tb_serial_adder;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;

  logic       start8 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0;
  logic       busy8, done8, cout8;
  logic [7:0] sum8;

  logic       start5 = 1'b0;
  logic [4:0] a5 = '0, b5 = '0;
  logic       busy5, done5, cout5;
  logic [4:0] sum5;

  int pass_cnt = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  serial_adder #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start_i(start8), .a_i(a8), .b_i(b8),
    .busy_o(busy8), .done_o(done8), .sum_o(sum8), .cout_o(cout8)
  );

  serial_adder #(.WIDTH(5)) dut5 (
    .clk(clk), .rst_n(rst_n), .start_i(start5), .a_i(a5), .b_i(b5),
    .busy_o(busy5), .done_o(done5), .sum_o(sum5), .cout_o(cout5)
  );

  // Stimulus only: pulse start, then count busy cycles until done (bounded).
  task automatic run_op8(input logic [7:0] a, input logic [7:0] b,
                         output int busy_n, output bit timeout);
    @(negedge clk);
    start8 = 1'b1; a8 = a; b8 = b;
    @(negedge clk);
    start8 = 1'b0;
    busy_n = 0;
    timeout = 1'b1;
    for (int i = 0; i < 40; i++) begin
      if (done8) begin timeout = 1'b0; break; end
      if (busy8) busy_n++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    total_cnt++;
    if ({busy8, done8, sum8, cout8} !== 11'd0)
      $display("FAIL reset_in: busy=%b done=%b sum=%h cout=%b want all 0", busy8, done8, sum8, cout8);
    else pass_cnt++;
    rst_n = 1'b1;
    @(negedge clk);
    total_cnt++;
    if ({busy8, done8, sum8, cout8} !== 11'd0)
      $display("FAIL reset_out: busy=%b done=%b sum=%h cout=%b want all 0", busy8, done8, sum8, cout8);
    else pass_cnt++;
  endtask

  task automatic test_zero();
    int n; bit to;
    run_op8(8'h00, 8'h00, n, to);
    total_cnt++;
    if (to || n != 8) $display("FAIL zero_busy: busy cycles=%0d timeout=%b want 8", n, to);
    else pass_cnt++;
    total_cnt++;
    if ({cout8, sum8} !== 9'h000) $display("FAIL zero_sum: got %h want 000", {cout8, sum8});
    else pass_cnt++;
    @(negedge clk);
    total_cnt++;
    if (done8 !== 1'b0 || busy8 !== 1'b0)
      $display("FAIL zero_pulse: done=%b busy=%b want 0 0", done8, busy8);
    else pass_cnt++;
  endtask

  task automatic test_ripple();
    int n; bit to;
    run_op8(8'hFF, 8'h01, n, to);
    total_cnt++;
    if (to || n != 8) $display("FAIL ripple_busy: busy cycles=%0d timeout=%b want 8", n, to);
    else pass_cnt++;
    total_cnt++;
    if ({cout8, sum8} !== 9'h100) $display("FAIL ripple_sum: got %h want 100", {cout8, sum8});
    else pass_cnt++;
  endtask

  task automatic test_ignore_start();
    int n; bit to;
    @(negedge clk);
    start8 = 1'b1; a8 = 8'hA5; b8 = 8'h5A;
    @(negedge clk);
    start8 = 1'b0;
    n = 0; to = 1'b1;
    for (int i = 0; i < 40; i++) begin
      if (done8) begin to = 1'b0; break; end
      if (busy8) n++;
      if (n == 3 && busy8) begin start8 = 1'b1; a8 = 8'h11; b8 = 8'h22; end
      else begin start8 = 1'b0; end
      @(negedge clk);
    end
    start8 = 1'b0;
    total_cnt++;
    if (to || n != 8) $display("FAIL ignore_busy: busy cycles=%0d timeout=%b want 8", n, to);
    else pass_cnt++;
    total_cnt++;
    if ({cout8, sum8} !== 9'h0FF) $display("FAIL ignore_sum: got %h want 0FF", {cout8, sum8});
    else pass_cnt++;
    a8 = 8'h33; b8 = 8'h44;
    repeat (3) @(negedge clk);
    total_cnt++;
    if (busy8 !== 1'b0 || {cout8, sum8} !== 9'h0FF)
      $display("FAIL ignore_hold: busy=%b result=%h want 0 0FF", busy8, {cout8, sum8});
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    int gap; bit to;
    @(negedge clk);
    start8 = 1'b1; a8 = 8'h0F; b8 = 8'h01;
    @(negedge clk);
    to = 1'b1;
    for (int i = 0; i < 40; i++) begin
      if (done8) begin to = 1'b0; break; end
      @(negedge clk);
    end
    total_cnt++;
    if (to || {cout8, sum8} !== 9'h010)
      $display("FAIL b2b_first: result=%h timeout=%b want 010", {cout8, sum8}, to);
    else pass_cnt++;
    a8 = 8'h80; b8 = 8'h80;
    gap = 0; to = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      gap++;
      if (i == 0) begin
        total_cnt++;
        if (busy8 !== 1'b1) $display("FAIL b2b_restart: busy=%b want 1", busy8);
        else pass_cnt++;
      end
      if (done8) begin to = 1'b0; break; end
    end
    start8 = 1'b0;
    total_cnt++;
    if (to || gap != 9) $display("FAIL b2b_period: gap=%0d timeout=%b want 9", gap, to);
    else pass_cnt++;
    total_cnt++;
    if ({cout8, sum8} !== 9'h100) $display("FAIL b2b_second: got %h want 100", {cout8, sum8});
    else pass_cnt++;
    @(negedge clk);
  endtask

  task automatic test_reset_abort();
    int n; bit to; bit saw_done;
    @(negedge clk);
    start8 = 1'b1; a8 = 8'h7F; b8 = 8'h7F;
    @(negedge clk);
    start8 = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    total_cnt++;
    if ({busy8, done8, sum8, cout8} !== 11'd0)
      $display("FAIL abort_async: busy=%b done=%b sum=%h cout=%b want all 0", busy8, done8, sum8, cout8);
    else pass_cnt++;
    @(negedge clk);
    rst_n = 1'b1;
    saw_done = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done8 || busy8) saw_done = 1'b1;
    end
    total_cnt++;
    if (saw_done) $display("FAIL abort_nodone: activity after abort=%b want 0", saw_done);
    else pass_cnt++;
    run_op8(8'h03, 8'h04, n, to);
    total_cnt++;
    if (to || {cout8, sum8} !== 9'h007)
      $display("FAIL abort_next: result=%h timeout=%b want 007", {cout8, sum8}, to);
    else pass_cnt++;
  endtask

  task automatic test_random();
    int overlap = 0;
    bit to;
    logic [7:0] ra, rb;
    logic [4:0] qa, qb;
    for (int k = 0; k < 1000; k++) begin
      ra = 8'($urandom); rb = 8'($urandom);
      @(negedge clk);
      start8 = 1'b1; a8 = ra; b8 = rb;
      @(negedge clk);
      start8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom);
      to = 1'b1;
      for (int i = 0; i < 40; i++) begin
        if (busy8 && done8) overlap++;
        if (done8) begin to = 1'b0; break; end
        @(negedge clk);
      end
      total_cnt++;
      if (to || {cout8, sum8} !== ({1'b0, ra} + {1'b0, rb}))
        $display("FAIL rand8: %h+%h got %h want %h timeout=%b", ra, rb, {cout8, sum8},
                 {1'b0, ra} + {1'b0, rb}, to);
      else pass_cnt++;
    end
    for (int k = 0; k < 1000; k++) begin
      qa = 5'($urandom); qb = 5'($urandom);
      @(negedge clk);
      start5 = 1'b1; a5 = qa; b5 = qb;
      @(negedge clk);
      start5 = 1'b0; a5 = 5'($urandom); b5 = 5'($urandom);
      to = 1'b1;
      for (int i = 0; i < 40; i++) begin
        if (busy5 && done5) overlap++;
        if (done5) begin to = 1'b0; break; end
        @(negedge clk);
      end
      total_cnt++;
      if (to || {cout5, sum5} !== ({1'b0, qa} + {1'b0, qb}))
        $display("FAIL rand5: %h+%h got %h want %h timeout=%b", qa, qb, {cout5, sum5},
                 {1'b0, qa} + {1'b0, qb}, to);
      else pass_cnt++;
    end
    total_cnt++;
    if (overlap != 0) $display("FAIL busy_done_overlap: count=%0d want 0", overlap);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_zero();
    test_ripple();
    test_ignore_start();
    test_back_to_back();
    test_reset_abort();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
